// File: rtl/lcd_framebuffer_pkg.sv
// lcd_framebuffer_pkg: shared LCD geometry for the PPU and the frame store
package lcd_framebuffer_pkg;
  localparam int LCD_W = 160;
  localparam int LCD_H = 144;
  localparam int LCD_PIXELS = LCD_W * LCD_H;
  localparam int LCD_ADDRBITS = 15;
endpackage

// File: rtl/lcd_framebuffer_fb_ram.sv
// fb_ram: simple dual-port 2-bit pixel RAM, one write port and one registered read port
module fb_ram #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata
);
  logic [1:0] mem [2**AW];
  // write and registered read; a same-cycle read of the written address returns old data
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/lcd_framebuffer.sv
// lcd_framebuffer: captures the LCD pixel stream into a frame store with a random-access read port.
// Define FB_DOUBLE_BUFFER_EN for a two-bank store that swaps on every vblank rise.
module lcd_framebuffer
  import lcd_framebuffer_pkg::*;
#(
  parameter int ADDRBITS = LCD_ADDRBITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_hblank,
  input  logic       lcd_vblank,
  input  logic       lcd_write,
  input  logic [1:0] lcd_col,
  input  logic [7:0] lcd_x,
  input  logic [7:0] lcd_y,
  input  logic       rd_en,
  input  logic [7:0] rd_x,
  input  logic [7:0] rd_y,
  output logic [1:0] rd_col,
  output logic       rd_valid,
  output logic       frame_done,
  output logic       frame_complete,
  output logic [7:0] frame_count,
  output logic       oob_err
);
  logic vb_q, rise, wr_in, rd_in, wr_ok, rd_ok, rd_zero, unused_hblank;
  logic [ADDRBITS-1:0] wr_addr, rd_addr, pix_cnt, pix_next;
  logic [1:0] ram_q;
  assign unused_hblank = lcd_hblank;
  assign rise = lcd_vblank & ~vb_q;
  assign wr_in = lcd_x < 8'(LCD_W) && lcd_y < 8'(LCD_H);
  assign rd_in = rd_x < 8'(LCD_W) && rd_y < 8'(LCD_H);
  assign wr_ok = lcd_write & wr_in;
  assign rd_ok = rd_en & rd_in;
  // y*160 as (y<<7)+(y<<5) avoids a multiplier
  assign wr_addr = ADDRBITS'({lcd_y, 7'b0}) + ADDRBITS'({lcd_y, 5'b0}) + ADDRBITS'(lcd_x);
  assign rd_addr = ADDRBITS'({rd_y, 7'b0}) + ADDRBITS'({rd_y, 5'b0}) + ADDRBITS'(rd_x);
  // a pixel coincident with the vblank rise still belongs to the finishing frame
  assign pix_next = wr_ok && pix_cnt != '1 ? pix_cnt + 1'b1 : pix_cnt;
  // out-of-range reads return 0 without touching RAM; the flag holds with rd_col between reads
  assign rd_col = rd_zero ? 2'd0 : ram_q;
`ifdef FB_DOUBLE_BUFFER_EN
  logic wr_bank;
  // write bank flips on each vblank rise; the display reads the other bank
  always_ff @(posedge clk) begin
    if (reset) wr_bank <= 1'b0;
    else if (rise) wr_bank <= ~wr_bank;
  end
  fb_ram #(.AW(ADDRBITS + 1)) u_ram (
    .clk(clk), .we(wr_ok), .waddr({wr_bank, wr_addr}), .wdata(lcd_col),
    .re(rd_ok), .raddr({~wr_bank, rd_addr}), .rdata(ram_q)
  );
`else
  fb_ram #(.AW(ADDRBITS)) u_ram (
    .clk(clk), .we(wr_ok), .waddr(wr_addr), .wdata(lcd_col),
    .re(rd_ok), .raddr(rd_addr), .rdata(ram_q)
  );
`endif
  // frame tracking, pixel counting, error flag and read handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      vb_q <= 1'b0;
      pix_cnt <= '0;
      frame_done <= 1'b0;
      frame_complete <= 1'b0;
      frame_count <= 8'd0;
      oob_err <= 1'b0;
      rd_valid <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      vb_q <= lcd_vblank;
      frame_done <= rise;
      pix_cnt <= rise ? '0 : pix_next;
      if (rise) begin
        frame_complete <= pix_next == ADDRBITS'(LCD_PIXELS);
        frame_count <= frame_count + 8'd1;
      end
      if (lcd_write && !wr_in) oob_err <= 1'b1;
      rd_valid <= rd_en;
      if (rd_en) rd_zero <= ~rd_in;
    end
  end
endmodule
